// File: rtl/oric_tap_loader.sv
`default_nettype none
// ============================================================================
// Module   : oric_tap_loader
// Brief    : Streams an Oric .TAP image from the ioctl download channel into
//            main RAM. Optional auto-start request: ORIC_TAP_AUTORUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module oric_tap_loader #(
    parameter logic [7:0] TAP_INDEX = 8'd1,
    parameter int         NAME_MAX  = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] ram_ad,
    output logic [7:0]  ram_d,
    output logic        ram_we,
    output logic        active,
    output logic        done,
    output logic        error,
    output logic        autorun_req,
    output logic [15:0] start_addr,
    output logic [15:0] end_addr
);

    localparam int            NW         = $clog2(NAME_MAX + 1);
    localparam logic [NW-1:0] NAME_LIMIT = NW'(NAME_MAX);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SYNC   = 4'd1,
        S_HDR    = 4'd2,
        S_NAME   = 4'd3,
        S_DATA   = 4'd4,
        S_FIX_LO = 4'd5,
        S_FIX_HI = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t          state_q;
    logic            dl_q;
    logic [1:0]      sync_cnt_q;
    logic [3:0]      hdr_idx_q;
    logic [NW-1:0]   name_cnt_q;
    logic            basic_q;
    logic [15:0]     ptr_q;
    logic [15:0]     start_q;
    logic [15:0]     end_q;
    logic [15:0]     ram_ad_q;
    logic [7:0]      ram_d_q;
    logic            ram_we_q;
    logic            active_q;
    logic            done_q;
    logic            error_q;
`ifdef ORIC_TAP_AUTORUN_EN
    logic            autorun_flag_q;
    logic            autorun_q;
`endif

    logic            w_rise;
    logic            w_fall;
    logic [15:0]     ptr_d;
    logic [15:0]     end_inc_d;
    logic            w_unused;

    assign w_rise    = ioctl_download & ~dl_q;
    assign w_fall    = ~ioctl_download & dl_q;
    assign ptr_d     = ptr_q + 16'd1;
    assign end_inc_d = end_q + 16'd1;
    assign w_unused  = ^ioctl_addr;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            sync_cnt_q <= 2'd0;
            hdr_idx_q  <= 4'd0;
            name_cnt_q <= '0;
            basic_q    <= 1'b0;
            ptr_q      <= 16'd0;
            start_q    <= 16'd0;
            end_q      <= 16'd0;
            ram_ad_q   <= 16'd0;
            ram_d_q    <= 8'd0;
            ram_we_q   <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef ORIC_TAP_AUTORUN_EN
            autorun_flag_q <= 1'b0;
            autorun_q      <= 1'b0;
`endif
        end else begin
            dl_q     <= ioctl_download;
            ram_we_q <= 1'b0;
`ifdef ORIC_TAP_AUTORUN_EN
            autorun_q <= 1'b0;
`endif
            // A matching download edge restarts the parse from any state.
            if (w_rise && ioctl_index == TAP_INDEX) begin
                state_q    <= S_SYNC;
                active_q   <= 1'b1;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                sync_cnt_q <= 2'd0;
                hdr_idx_q  <= 4'd0;
                name_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_SYNC, S_HDR, S_NAME, S_DATA: begin
                        if (w_fall) begin
                            state_q <= S_ERR;
                        end else if (ioctl_wr) begin
                            case (state_q)
                                S_SYNC: begin
                                    if (ioctl_dout == 8'h16) begin
                                        if (sync_cnt_q != 2'd3) sync_cnt_q <= sync_cnt_q + 2'd1;
                                    end else if (ioctl_dout == 8'h24 && sync_cnt_q == 2'd3) begin
                                        state_q <= S_HDR;
                                    end else begin
                                        state_q <= S_ERR;
                                    end
                                end
                                S_HDR: begin
                                    hdr_idx_q <= hdr_idx_q + 4'd1;
                                    case (hdr_idx_q)
                                        4'd2: basic_q <= (ioctl_dout == 8'h00);
`ifdef ORIC_TAP_AUTORUN_EN
                                        4'd3: autorun_flag_q <= (ioctl_dout != 8'h00);
`endif
                                        4'd4: end_q[15:8]   <= ioctl_dout;
                                        4'd5: end_q[7:0]    <= ioctl_dout;
                                        4'd6: start_q[15:8] <= ioctl_dout;
                                        4'd7: start_q[7:0]  <= ioctl_dout;
                                        4'd8: begin
                                            if (end_q < start_q) begin
                                                state_q <= S_ERR;
                                            end else begin
                                                state_q <= S_NAME;
                                                ptr_q   <= start_q;
                                            end
                                        end
                                        default: ;
                                    endcase
                                end
                                S_NAME: begin
                                    if (ioctl_dout == 8'h00) begin
                                        state_q <= S_DATA;
                                    end else if (name_cnt_q == NAME_LIMIT) begin
                                        state_q <= S_ERR;
                                    end else begin
                                        name_cnt_q <= name_cnt_q + 1'b1;
                                    end
                                end
                                default: begin
                                    ram_ad_q <= ptr_q;
                                    ram_d_q  <= ioctl_dout;
                                    ram_we_q <= 1'b1;
                                    ptr_q    <= ptr_d;
                                    // Equality stop, so end==FFFF never relies on wrap.
                                    if (ptr_q == end_q) state_q <= basic_q ? S_FIX_LO : S_DONE;
                                end
                            endcase
                        end
                    end
                    S_FIX_LO: begin
                        ram_ad_q <= 16'h009C;
                        ram_d_q  <= end_inc_d[7:0];
                        ram_we_q <= 1'b1;
                        state_q  <= S_FIX_HI;
                    end
                    S_FIX_HI: begin
                        ram_ad_q <= 16'h009D;
                        ram_d_q  <= end_inc_d[15:8];
                        ram_we_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    S_DONE: begin
                        if (!ioctl_download) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
`ifdef ORIC_TAP_AUTORUN_EN
                            autorun_q <= autorun_flag_q;
`endif
                        end
                    end
                    S_ERR: begin
                        if (!ioctl_download) begin
                            active_q <= 1'b0;
                            error_q  <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_ad     = ram_ad_q;
    assign ram_d      = ram_d_q;
    assign ram_we     = ram_we_q;
    assign active     = active_q;
    assign done       = done_q;
    assign error      = error_q;
    assign start_addr = start_q;
    assign end_addr   = end_q;
`ifdef ORIC_TAP_AUTORUN_EN
    assign autorun_req = autorun_q;
`else
    assign autorun_req = 1'b0;
`endif

endmodule
`default_nettype wire
